// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge
//   Data-side memory for the 5-stage pipeline, directly downstream of the MEM stage.
//   It decodes a word RAM and an MMIO page. The MMIO page holds an LED register, a
//   free-running cycle counter and a FIFO-buffered 8N1 UART transmitter.
//
// Address map (word granular, Addr_in[1:0] only matters for store alignment)
//   0x0000_0000 .. DEPTH_WORDS*4-1 : RAM, read/write
//   0xF000_0000 : LED, read/write, bits [15:0]
//   0xF000_0004 : CYCLE, read-only 32-bit counter
//   0xF000_0008 : TXDATA, write-only (pushes [7:0]), reads 0
//   0xF000_000C : STATUS, read-only {cnt[8+:CNT_W], ovf[3], busy[2], empty[1], full[0]}
//                 Writing 1 to bit 3 clears ovf.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   Addr_in      : byte address from EX/MEM
//   Data_wr_in   : store data from EX/MEM
//   MemRW_in     : 1 = store this cycle, 0 = read
//   Data_rd_out  : combinational read data for Addr_in
//   led_out      : LED register
//   uart_tx      : serial line, idle high
//   err_out      : sticky bus-error flag
//   tx_state_dbg : current UART FSM state (0 idle, 1 start, 2 data, 3 stop)
//
// Handshake: there is no valid/ready pair. Each cycle with MemRW_in=1 is exactly one
// store, committed on that rising edge. Reads are combinational and have no side
// effects, because Addr_in is live on every instruction.
module dmem_mmio_bridge #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_wr_in,
  input  logic        MemRW_in,
  output logic [31:0] Data_rd_out,
  output logic [15:0] led_out,
  output logic        uart_tx,
  output logic        err_out,
  output logic [1:0]  tx_state_dbg
);

  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Word addresses (byte address >> 2) of the MMIO registers.
  localparam logic [29:0] W_LED  = 30'h3C00_0000;
  localparam logic [29:0] W_CYC  = 30'h3C00_0001;
  localparam logic [29:0] W_TX   = 30'h3C00_0002;
  localparam logic [29:0] W_STAT = 30'h3C00_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // ---------------- address decode ----------------
  logic [29:0]       word_addr;
  logic              aligned;
  logic              sel_ram, sel_led, sel_cyc, sel_tx, sel_stat, sel_any;
  logic              store;
  logic [RAM_AW-1:0] ram_idx;

  assign word_addr = Addr_in[31:2];
  assign aligned   = (Addr_in[1:0] == 2'b00);
  assign sel_ram   = (Addr_in[31:RAM_AW+2] == '0);
  assign sel_led   = (word_addr == W_LED);
  assign sel_cyc   = (word_addr == W_CYC);
  assign sel_tx    = (word_addr == W_TX);
  assign sel_stat  = (word_addr == W_STAT);
  assign sel_any   = sel_ram | sel_led | sel_cyc | sel_tx | sel_stat;
  assign ram_idx   = Addr_in[RAM_AW+1:2];
  // A misaligned store is dropped entirely; only err records it.
  assign store     = MemRW_in & aligned;

  // ---------------- state ----------------
  logic [31:0]      ram [DEPTH_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [15:0]      led_q;
  logic [31:0]      cycle_q;
  logic             ovf_q, err_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  tx_state_t        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             pop;
  logic             tx_bit;

  logic fifo_full, fifo_empty, push_req, push_ok, push_drop, busy, bit_end;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = store & sel_tx;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign push_drop  = push_req & fifo_full & ~pop;
  assign busy       = (state_q != S_IDLE);
  assign bit_end    = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));

  // RAM and FIFO storage have no reset. A reset cycle is not an instruction, so a
  // store presented while rst is high is not committed.
  always_ff @(posedge clk) begin
    if (!rst && store && sel_ram) ram[ram_idx] <= Data_wr_in;
    if (!rst && push_ok) fifo_mem[wr_ptr_q] <= Data_wr_in[7:0];
  end

  // ---------------- registers, counter, FIFO bookkeeping ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      cycle_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (store && sel_led) led_q <= Data_wr_in[15:0];
      if (MemRW_in && (!aligned || !sel_any)) err_q <= 1'b1;
      if (push_drop) ovf_q <= 1'b1;
      else if (store && sel_stat && Data_wr_in[3]) ovf_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop) count_q <= count_q + CNT_W'(1);
      else if (pop && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  // ---------------- UART FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // ---------------- UART FSM: next state and outputs ----------------
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_bit  = 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_bit = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          tmr_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        tx_bit = shift_q[0];
        if (bit_end) begin
          tmr_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_STOP: begin
        tx_bit = 1'b1;
        // Returning to IDLE lets the next byte be popped on the following edge.
        if (bit_end) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  logic [31:0] status_word;

  always_comb begin
    status_word = '0;
    status_word[8 +: CNT_W] = count_q;
    status_word[3] = ovf_q;
    status_word[2] = busy;
    status_word[1] = fifo_empty;
    status_word[0] = fifo_full;
  end

  always_comb begin
    Data_rd_out = '0;
    if (sel_ram)       Data_rd_out = ram[ram_idx];
    else if (sel_led)  Data_rd_out = {16'h0000, led_q};
    else if (sel_cyc)  Data_rd_out = cycle_q;
    else if (sel_stat) Data_rd_out = status_word;
  end

  assign led_out      = led_q;
  assign err_out      = err_q;
  assign uart_tx      = tx_bit;
  assign tx_state_dbg = state_q;

endmodule
